// File: rtl/collision_pkg.sv
// Shared constants, stage-1 pixel record and colour-match rule for the collision detector.
package collision_pkg;

  localparam int unsigned COLOR_W         = 4;
  localparam int unsigned NUM_CH_DEFAULT  = 5;
  localparam int unsigned CNT_W_DEFAULT   = 10;

  typedef struct packed {
    logic valid;
    logic match;
  } pix_stage_t;

  // Sums are widened by one bit so a large green/blue plus margin never wraps below red.
  function automatic logic color_match(
    input logic [COLOR_W-1:0] red,
    input logic [COLOR_W-1:0] green,
    input logic [COLOR_W-1:0] blue,
    input logic [COLOR_W-1:0] hit_level,
    input logic [COLOR_W-1:0] hit_margin
  );
    logic [COLOR_W:0] g_sum;
    logic [COLOR_W:0] b_sum;
    g_sum = {1'b0, green} + {1'b0, hit_margin};
    b_sum = {1'b0, blue}  + {1'b0, hit_margin};
    return (red > hit_level) && ({1'b0, red} > g_sum) && ({1'b0, red} > b_sum);
  endfunction

endpackage

// File: rtl/collision_ch_counter.sv
// One collision channel: saturating per-frame hit counter, frame verdict and rising-edge pulse.
module collision_ch_counter
  import collision_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk_25MHz,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             armed,
  input  logic             count_en,
  input  logic             hit,
  input  logic [CNT_W-1:0] thr_cnt,
  output logic             detected,
  output logic             pulse
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] thr_eff;
  logic             inc;
  logic             verdict;

  always_comb begin
    thr_eff = (thr_cnt == '0) ? CNT_W'(1) : thr_cnt;
    inc     = hit & count_en;
    verdict = armed & count_en & (cnt >= thr_eff);
  end

  // A hit coinciding with frame_start belongs to the frame that is just starting.
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      cnt      <= '0;
      detected <= 1'b0;
      pulse    <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (frame_start) begin
        detected <= verdict;
        pulse    <= verdict & ~detected;
        cnt      <= CNT_W'(inc);
      end else if (!count_en) begin
        cnt <= '0;
      end else if (inc && (cnt != '1)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/collision_frame_detector.sv
// Per-channel red-object collision detector over a video frame.
// Optional COLLISION_STICKY_EN adds sticky_clr / collision_sticky.
module collision_frame_detector
  import collision_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEFAULT,
  parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
  input  logic               clk_25MHz,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               pixel_valid,
  input  logic [COLOR_W-1:0] red,
  input  logic [COLOR_W-1:0] green,
  input  logic [COLOR_W-1:0] blue,
  input  logic [NUM_CH-1:0]  collision_area,
  input  logic [NUM_CH-1:0]  collision_en,
  input  logic [COLOR_W-1:0] hit_level,
  input  logic [COLOR_W-1:0] hit_margin,
  input  logic [CNT_W-1:0]   thr_cnt,
`ifdef COLLISION_STICKY_EN
  input  logic               sticky_clr,
  output logic [NUM_CH-1:0]  collision_sticky,
`endif
  output logic [NUM_CH-1:0]  collision_detected,
  output logic [NUM_CH-1:0]  collision_pulse
);

  pix_stage_t        s1;
  logic [NUM_CH-1:0] s1_area;
  logic [NUM_CH-1:0] s1_en;
  logic              armed;

  // armed stays low until the first frame_start after reset, so that partial frame is never judged.
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      s1      <= '0;
      s1_area <= '0;
      s1_en   <= '0;
      armed   <= 1'b0;
    end else begin
      s1.valid <= pixel_valid;
      s1.match <= color_match(red, green, blue, hit_level, hit_margin);
      s1_area  <= collision_area;
      s1_en    <= collision_en;
      if (frame_start) armed <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    collision_ch_counter #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_25MHz  (clk_25MHz),
      .reset      (reset),
      .frame_start(frame_start),
      .armed      (armed),
      .count_en   (s1_en[i]),
      .hit        (s1.valid & s1_area[i] & s1.match),
      .thr_cnt    (thr_cnt),
      .detected   (collision_detected[i]),
      .pulse      (collision_pulse[i])
    );
  end

`ifdef COLLISION_STICKY_EN
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      collision_sticky <= '0;
    end else begin
      collision_sticky <= collision_pulse | (collision_sticky & ~{NUM_CH{sticky_clr}});
    end
  end
`endif

endmodule
